// File: rtl/onchip_mem_master_pkg.sv
// -----------------------------------------------------------------------------
// onchip_mem_master_pkg
// Shared types and default sizes for the on-chip RAM initiator.
//   op_e    : command opcodes carried on cmd_op
//   state_e : controller states
//   DEF_ADDR_W / DEF_DATA_W : default word-address and data widths
// -----------------------------------------------------------------------------
package onchip_mem_master_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FILL  = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/onchip_mem_master_obuf.sv
// -----------------------------------------------------------------------------
// onchip_mem_master_obuf
// Synchronous FIFO holding words read from the RAM until the rd stream takes
// them. DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (contents cleared)
//   i_push, i_din  : write a word (ignored when full without a pop)
//   i_pop          : remove the head word (ignored when empty)
//   o_dout         : head word
//   o_count        : current occupancy, 0..DEPTH
// A push and a pop in the same cycle on a full FIFO are both honoured.
// -----------------------------------------------------------------------------
module onchip_mem_master_obuf #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_din,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_dout,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW:0]       r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign w_pop_ok  = i_pop && (r_count != '0);
  // a full buffer may still accept a word when the head leaves this cycle
  assign w_push_ok = i_push && ((r_count != (PW+1)'(DEPTH)) || w_pop_ok);

  // storage, pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/onchip_mem_master.sv
// -----------------------------------------------------------------------------
// onchip_mem_master
// Avalon-MM initiator for a single-port on-chip RAM (read latency 1).
// Executes one command at a time: READ (RAM -> rd stream), WRITE
// (wr stream -> RAM) or FILL (constant -> RAM). Op 3 is accepted as a no-op.
// Ports:
//   clk, reset_n                     : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              : command handshake (ready only in IDLE)
//   cmd_op/addr/len/pattern/be       : command fields, latched on accept
//   wr_data/wr_valid/wr_ready        : write stream (ready only in WRITE)
//   rd_data/rd_valid/rd_ready        : read stream out of the read buffer
//   done                             : one-cycle pulse at completion
//   busy                             : state is not IDLE
//   m_*                              : RAM slave side; m_clken tied high
// Optional build macro ONCHIP_MEM_MASTER_CHECKSUM_EN adds output `checksum`,
// the XOR of every word written or captured during the current command.
// -----------------------------------------------------------------------------
module onchip_mem_master
  import onchip_mem_master_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int OBUF_DEPTH = 2
) (
`ifdef ONCHIP_MEM_MASTER_CHECKSUM_EN
  output logic [DATA_W-1:0]   checksum,
`endif
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic [DATA_W-1:0]   cmd_pattern,
  input  logic [DATA_W/8-1:0] cmd_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                done,
  output logic                busy,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic                m_clken,
  input  logic [DATA_W-1:0]   m_readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int CW   = $clog2(OBUF_DEPTH) + 1;

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remain;
  logic [DATA_W-1:0] r_pattern;
  logic [BE_W-1:0]   r_be;
  logic              r_inflight;

  logic              w_accept;
  logic              w_wr_fire;
  logic              w_fill_fire;
  logic              w_rd_issue;
  logic              w_last;
  logic              w_pop;
  logic [CW-1:0]     w_count;
  logic [DATA_W-1:0] w_head;

  assign w_accept    = cmd_valid && (r_state == ST_IDLE);
  assign w_wr_fire   = (r_state == ST_WRITE) && wr_valid;
  assign w_fill_fire = (r_state == ST_FILL);
  // a read is only issued when its data is guaranteed a buffer slot
  assign w_rd_issue  = (r_state == ST_READ) &&
                       ((int'(w_count) + int'(r_inflight)) < OBUF_DEPTH);
  assign w_last      = (r_remain == (ADDR_W+1)'(1));
  assign w_pop       = rd_valid && rd_ready;

  // command sequencing: latch on accept, step address/count per access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_remain  <= '0;
      r_pattern <= '0;
      r_be      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr    <= cmd_addr;
            r_remain  <= cmd_len;
            r_pattern <= cmd_pattern;
            r_be      <= cmd_be;
            if (cmd_len == '0) begin
              r_state <= ST_DONE;
            end else begin
              case (cmd_op)
                OP_READ:  r_state <= ST_READ;
                OP_WRITE: r_state <= ST_WRITE;
                OP_FILL:  r_state <= ST_FILL;
                default:  r_state <= ST_DONE;
              endcase
            end
          end
        end
        ST_READ: begin
          if (w_rd_issue) begin
            r_addr   <= r_addr + ADDR_W'(1);
            r_remain <= r_remain - (ADDR_W+1)'(1);
            if (w_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_WRITE: begin
          if (w_wr_fire) begin
            r_addr   <= r_addr + ADDR_W'(1);
            r_remain <= r_remain - (ADDR_W+1)'(1);
            if (w_last) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_FILL: begin
          r_addr   <= r_addr + ADDR_W'(1);
          r_remain <= r_remain - (ADDR_W+1)'(1);
          if (w_last) begin
            r_state <= ST_DONE;
          end
        end
        // the single outstanding read is captured at this same edge
        ST_DRAIN: r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // one read in flight at most; its data arrives the following cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_issue;
    end
  end

  onchip_mem_master_obuf #(
    .DEPTH  (OBUF_DEPTH),
    .DATA_W (DATA_W)
  ) u_obuf (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (r_inflight),
    .i_din   (m_readdata),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_count)
  );

  // RAM bus drive: idle unless an access is issued this cycle
  always_comb begin
    m_chipselect = 1'b0;
    m_write      = 1'b0;
    m_address    = r_addr;
    m_byteenable = '0;
    m_writedata  = '0;
    if (w_rd_issue) begin
      m_chipselect = 1'b1;
      m_byteenable = '1;
    end else if (w_wr_fire) begin
      m_chipselect = 1'b1;
      m_write      = 1'b1;
      m_byteenable = r_be;
      m_writedata  = wr_data;
    end else if (w_fill_fire) begin
      m_chipselect = 1'b1;
      m_write      = 1'b1;
      m_byteenable = r_be;
      m_writedata  = r_pattern;
    end else begin
      m_chipselect = 1'b0;
    end
  end

  assign m_clken   = 1'b1;
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign wr_ready  = (r_state == ST_WRITE);
  assign rd_valid  = (w_count != '0);
  assign rd_data   = w_head;

`ifdef ONCHIP_MEM_MASTER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  // running XOR of words moved this command; cleared on accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= '0;
    end else if (r_inflight) begin
      r_csum <= r_csum ^ m_readdata;
    end else if (m_chipselect && m_write) begin
      r_csum <= r_csum ^ m_writedata;
    end else begin
      r_csum <= r_csum;
    end
  end

  assign checksum = r_csum;
`endif

endmodule

// File: tb/tb_onchip_mem_master.sv
`timescale 1ns/1ps
module tb_onchip_mem_master;

  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 8192;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic [DW-1:0] cmd_pattern = '0;
  logic [BW-1:0] cmd_be = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          done;
  logic          busy;
  logic [AW-1:0] m_address;
  logic [BW-1:0] m_byteenable;
  logic          m_chipselect;
  logic          m_write;
  logic [DW-1:0] m_writedata;
  logic          m_clken;
  logic [DW-1:0] m_readdata = '0;
`ifdef ONCHIP_MEM_MASTER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  onchip_mem_master dut (
`ifdef ONCHIP_MEM_MASTER_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_pattern  (cmd_pattern),
    .cmd_be       (cmd_be),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .done         (done),
    .busy         (busy),
    .m_address    (m_address),
    .m_byteenable (m_byteenable),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_writedata  (m_writedata),
    .m_clken      (m_clken),
    .m_readdata   (m_readdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // RAM slave model, reference memory and monitors
  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          lat_cs, lat_we;
  logic [AW-1:0] lat_a;
  logic [DW-1:0] lat_d;
  logic [BW-1:0] lat_be;

  int            wlog_a[$];
  logic [DW-1:0] wlog_d[$];
  logic [BW-1:0] wlog_b[$];
  int            wlog_c[$];
  logic [DW-1:0] rlog[$];
  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] wsrc[$];
  int cyc = 0, issues = 0, pops = 0, max_out = 0, done_cnt = 0;
  int bus_viol = 0, stab_viol = 0;
  int rd_prob = 100, wr_prob = 100, hold_cycles = 0;
  bit wr_fire_seen = 1'b0, prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(posedge clk) begin
    if (lat_cs) begin
      if (lat_we) begin
        for (int b = 0; b < BW; b++)
          if (lat_be[b]) ram[lat_a][8*b +: 8] = lat_d[8*b +: 8];
      end else begin
        m_readdata <= ram[lat_a];
      end
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    lat_cs = m_chipselect; lat_we = m_write; lat_a = m_address;
    lat_d = m_writedata; lat_be = m_byteenable;
    if (!reset_n) begin
      lat_cs = 1'b0; prev_stall = 1'b0; wr_fire_seen = 1'b0; issues = 0; pops = 0;
    end else begin
      if (m_chipselect && m_write) begin
        wlog_a.push_back(int'(m_address)); wlog_d.push_back(m_writedata);
        wlog_b.push_back(m_byteenable); wlog_c.push_back(cyc);
      end
      if (m_chipselect && !m_write) begin
        issues++;
        if (m_byteenable !== 4'hF) bus_viol++;
      end
      if (!m_chipselect && m_write) bus_viol++;
      if (m_clken !== 1'b1) bus_viol++;
      if (issues - pops > max_out) max_out = issues - pops;
      if (prev_stall && (rd_valid !== 1'b1 || rd_data !== prev_data)) stab_viol++;
      if (rd_valid && rd_ready) begin rlog.push_back(rd_data); pops++; end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      if (done) done_cnt++;
      wr_fire_seen = wr_valid && wr_ready;
    end
  end

  // stream drivers: random rd_ready back-pressure, gapped wr_valid
  initial forever begin
    @(posedge clk); #1;
    if (hold_cycles > 0) begin rd_ready = 1'b0; hold_cycles--; end
    else rd_ready = (int'($urandom_range(99)) < rd_prob);
    if (wr_fire_seen) begin
      if (wr_q.size() > 0) void'(wr_q.pop_front());
      wr_valid = 1'b0;
    end
    if (!wr_valid && wr_q.size() > 0 && int'($urandom_range(99)) < wr_prob) begin
      wr_valid = 1'b1; wr_data = wr_q[0];
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // issue one command, then compare bus writes, read stream and done timing
  task automatic run_cmd(input int op, input int addr, input int len, input logic [31:0] pat,
                         input logic [3:0] be, input int exp_lat, input string nm,
                         output logic [31:0] first_rd);
    logic [31:0] exp_rd[$];
    int          ea[$];
    logic [31:0] ed[$];
    logic [31:0] mask, d, csum;
    int a, lat, d0, bad;
    bit got;
    csum = '0;
    mask = '0;
    for (int b = 0; b < 4; b++) if (be[b]) mask[8*b +: 8] = 8'hFF;
    for (int i = 0; i < len && op != 3; i++) begin
      a = (addr + i) % DEPTH;
      if (op == 0) begin
        exp_rd.push_back(ref_mem[a]); csum ^= ref_mem[a];
      end else begin
        d = (op == 1) ? wsrc[i] : pat;
        ref_mem[a] = (ref_mem[a] & ~mask) | (d & mask);
        ea.push_back(a); ed.push_back(d); csum ^= d;
      end
    end
    wlog_a.delete(); wlog_d.delete(); wlog_b.delete(); wlog_c.delete(); rlog.delete();
    d0 = done_cnt;
    if (op == 1 && len > 0) wr_q = wsrc;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_addr = AW'(addr); cmd_len = (AW+1)'(len);
    cmd_pattern = pat; cmd_be = be;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin @(negedge clk); got = cmd_ready; end
    chk({nm, "_accept"}, got, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    lat = 0; got = 1'b0;
    for (int t = 0; t < len * 25 + 50 && !got; t++) begin @(negedge clk); lat++; got = done; end
    chk({nm, "_done_seen"}, got, 1);
    if (exp_lat >= 0) chk({nm, "_done_lat"}, lat, exp_lat);
    for (int t = 0; t < 3000 && (rlog.size() < exp_rd.size() || rd_valid); t++) @(negedge clk);
    @(negedge clk);
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    chk({nm, "_wr_count"}, wlog_a.size(), ea.size());
    bad = 0;
    if (wlog_a.size() == ea.size())
      foreach (ea[i]) if (wlog_a[i] != ea[i] || wlog_d[i] !== ed[i] || wlog_b[i] !== be) bad++;
    chk({nm, "_wr_content_bad"}, bad, 0);
    chk({nm, "_rd_count"}, rlog.size(), exp_rd.size());
    bad = 0;
    if (rlog.size() == exp_rd.size())
      foreach (exp_rd[i]) if (rlog[i] !== exp_rd[i]) bad++;
    chk({nm, "_rd_content_bad"}, bad, 0);
    if (op == 2 && len > 1 && wlog_c.size() == len)
      chk({nm, "_fill_span"}, wlog_c[len-1] - wlog_c[0], len - 1);
`ifdef ONCHIP_MEM_MASTER_CHECKSUM_EN
    chk({nm, "_checksum"}, checksum, csum);
`endif
    first_rd = (rlog.size() > 0) ? rlog[0] : 32'h0;
  endtask

  typedef struct {
    int          op;
    int          addr;
    int          len;
    logic [31:0] pat;
    logic [3:0]  be;
    int          exp_lat;
    bit          has_word;
    logic [31:0] exp_word;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] first;
  bit          found;
  int          d0, op, addr, len;

  initial begin
    vecs[0] = '{2, 'h010, 4, 32'hDEADBEEF, 4'hF, 5, 1'b0, 32'h0};
    vecs[1] = '{0, 'h010, 4, 32'h0,        4'hF, -1, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{3, 'h020, 5, 32'h0,        4'hF, 1, 1'b0, 32'h0};
    vecs[3] = '{2, 'h030, 0, 32'h55555555, 4'hF, 1, 1'b0, 32'h0};
    vecs[4] = '{2, 'h1FFF, 2, 32'h12345678, 4'hC, 3, 1'b0, 32'h0};
    vecs[5] = '{0, 'h1FFF, 2, 32'h0,       4'hF, -1, 1'b1, 32'h12340000};
    vecs[6] = '{2, 'h100, 1, 32'hAABBCCDD, 4'hF, 2, 1'b0, 32'h0};

    for (int i = 0; i < DEPTH; i++) begin ram[i] = '0; ref_mem[i] = '0; end

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", done, 0);
    chk("rst_cs", m_chipselect, 0);
    chk("rst_write", m_write, 0);
    chk("rst_addr", m_address, 0);
    chk("rst_be", m_byteenable, 0);
    chk("rst_wdata", m_writedata, 0);
    chk("rst_clken", m_clken, 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed table
    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].addr, vecs[i].len, vecs[i].pat, vecs[i].be,
              vecs[i].exp_lat, $sformatf("vec%0d", i), first);
      if (vecs[i].has_word) chk($sformatf("vec%0d_first_word", i), first, vecs[i].exp_word);
    end

    // partial byteenable write over a known word
    wr_prob = 40;
    wsrc = '{32'h11223344};
    run_cmd(1, 'h100, 1, 32'h0, 4'h3, -1, "be_write", first);
    run_cmd(0, 'h100, 1, 32'h0, 4'hF, -1, "be_read", first);
    chk("be_readback", first, 32'hAABB3344);

    // gapped write stream that wraps past the top of memory
    wsrc = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_cmd(1, 'h1FFE, 4, 32'h0, 4'hF, -1, "wrap_write", first);
    run_cmd(0, 'h1FFE, 4, 32'h0, 4'hF, -1, "wrap_read", first);
    chk("wrap_first", first, 32'd1);
    wr_prob = 100;

    // read with rd_ready held low: buffer fills, nothing lost, data held
    wsrc.delete();
    for (int i = 0; i < 8; i++) wsrc.push_back(32'h100 + 32'(i));
    run_cmd(1, 'h200, 8, 32'h0, 4'hF, -1, "stall_fill", first);
    max_out = 0; stab_viol = 0; hold_cycles = 8;
    run_cmd(0, 'h200, 8, 32'h0, 4'hF, -1, "stall_read", first);
    chk("stall_max_outstanding", max_out, 2);
    chk("stall_rd_stable_viol", stab_viol, 0);
    chk("stall_first", first, 32'h100);

    // reset in the middle of a long read
    rd_prob = 100;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 13'h300; cmd_len = 14'd16;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin @(negedge clk); found = cmd_ready; end
    @(posedge clk); #1 cmd_valid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(posedge clk); #4;
      found = m_chipselect && rd_valid;
    end
    chk("mid_rst_active_before", found, 1);
    d0 = done_cnt;
    reset_n = 1'b0; #1;
    chk("mid_rst_cs_async", m_chipselect, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    run_cmd(0, 'h010, 4, 32'h0, 4'hF, -1, "post_rst_read", first);
    chk("post_rst_first", first, 32'hDEADBEEF);

    // full-depth fill: length 2**ADDR_W
    run_cmd(2, 5, DEPTH, 32'h5A5A0F0F, 4'hF, DEPTH + 1, "full_fill", first);

    // randomized commands against the reference memory
    for (int n = 0; n < 30; n++) begin
      op   = int'($urandom_range(3));
      addr = ($urandom_range(1) == 1) ? int'($urandom_range(DEPTH - 1))
                                      : DEPTH - int'($urandom_range(6, 1));
      len  = int'($urandom_range(10));
      rd_prob = int'($urandom_range(100, 30));
      wr_prob = int'($urandom_range(100, 30));
      wsrc.delete();
      for (int i = 0; i < len; i++) wsrc.push_back($urandom);
      run_cmd(op, addr, len, $urandom, 4'($urandom_range(15)),
              (len == 0 || op == 3) ? 1 : ((op == 2) ? len + 1 : -1),
              $sformatf("rnd%0d", n), first);
    end

    chk("bus_idle_viol", bus_viol, 0);
    chk("rd_stable_viol", stab_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
